// File: rtl/i2s_decoder.sv
// i2s_decoder: recovers left/right PCM words from an external I2S stream
// (LRCLK, BCLK, serial data) that is asynchronous to clk.
// Optional feature macro: I2S_DECODER_SYNC2_EN selects a two-flop input
// synchronizer (3-clk input-to-detection latency). When the macro is left
// undefined, a single input register is used (2-clk latency).
// Handshake: l_valid_o / r_valid_o / frame_valid_o / short_frame_o are
// single-clk strobes with no ready; l_chan_o / r_chan_o are valid from a
// strobe until the next strobe of the same channel and hold their value
// in between.
module i2s_decoder #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lrclk_i,
  input  logic                 bclk_i,
  input  logic                 dacdat_i,
  output logic [DATA_BITS-1:0] l_chan_o,
  output logic [DATA_BITS-1:0] r_chan_o,
  output logic                 l_valid_o,
  output logic                 r_valid_o,
  output logic                 frame_valid_o,
  output logic                 short_frame_o
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Input capture: bit 2 = lrclk, bit 1 = bclk, bit 0 = dacdat
`ifdef I2S_DECODER_SYNC2_EN
  logic [2:0] meta_q, meta_d;
`endif
  logic [2:0] sync_q, sync_d;
  logic       lr_h_q, lr_h_d;
  logic       bclk_h_q, bclk_h_d;

  state_t                 state_q, state_d;
  logic                   chan_q, chan_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   l_chan_q, l_chan_d;
  logic [DATA_BITS-1:0]   r_chan_q, r_chan_d;
  logic                   l_valid_q, l_valid_d;
  logic                   r_valid_q, r_valid_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   short_frame_q, short_frame_d;
  logic                   frame_ok_q, frame_ok_d;

  logic                   lr_s, bclk_s, dat_s;
  logic                   lr_edge, bclk_rise;
  logic [DATA_BITS-1:0]   word_w;

  // Synchronizer and edge-history next values
  always_comb begin
`ifdef I2S_DECODER_SYNC2_EN
    meta_d = {lrclk_i, bclk_i, dacdat_i};
    sync_d = meta_q;
`else
    sync_d = {lrclk_i, bclk_i, dacdat_i};
`endif
    lr_s      = sync_q[2];
    bclk_s    = sync_q[1];
    dat_s     = sync_q[0];
    lr_h_d    = lr_s;
    bclk_h_d  = bclk_s;
    lr_edge   = lr_s ^ lr_h_q;
    bclk_rise = bclk_s & ~bclk_h_q;
  end

  // Capture FSM: next state, shifter, counter and output strobes
  always_comb begin
    state_d       = state_q;
    chan_d        = chan_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    l_chan_d      = l_chan_q;
    r_chan_d      = r_chan_q;
    l_valid_d     = 1'b0;
    r_valid_d     = 1'b0;
    frame_valid_d = 1'b0;
    short_frame_d = 1'b0;
    frame_ok_d    = frame_ok_q;
    word_w        = {shift_q[DATA_BITS-2:0], dat_s};

    if (lr_edge) begin
      // A word-clock edge always restarts capture; a coincident BCLK rise
      // is consumed as the one-bit delay slot.
      chan_d  = lr_s;
      cnt_d   = '0;
      shift_d = '0;
      state_d = bclk_rise ? SHIFT : SKIP;
      if (state_q == SKIP || state_q == SHIFT) begin
        short_frame_d = 1'b1;
        frame_ok_d    = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SKIP: begin
          if (bclk_rise) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (bclk_rise) begin
            shift_d = word_w;
            if (cnt_q == CW'(DATA_BITS - 1)) begin
              cnt_d   = CW'(DATA_BITS);
              state_d = HOLD;
              if (chan_q) begin
                r_chan_d      = word_w;
                r_valid_d     = 1'b1;
                frame_valid_d = frame_ok_q;
                frame_ok_d    = 1'b0;
              end else begin
                l_chan_d   = word_w;
                l_valid_d  = 1'b1;
                frame_ok_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // All state registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef I2S_DECODER_SYNC2_EN
      meta_q        <= '0;
`endif
      sync_q        <= '0;
      lr_h_q        <= 1'b0;
      bclk_h_q      <= 1'b0;
      state_q       <= IDLE;
      chan_q        <= 1'b0;
      cnt_q         <= '0;
      shift_q       <= '0;
      l_chan_q      <= '0;
      r_chan_q      <= '0;
      l_valid_q     <= 1'b0;
      r_valid_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      short_frame_q <= 1'b0;
      frame_ok_q    <= 1'b0;
    end else begin
`ifdef I2S_DECODER_SYNC2_EN
      meta_q        <= meta_d;
`endif
      sync_q        <= sync_d;
      lr_h_q        <= lr_h_d;
      bclk_h_q      <= bclk_h_d;
      state_q       <= state_d;
      chan_q        <= chan_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      l_chan_q      <= l_chan_d;
      r_chan_q      <= r_chan_d;
      l_valid_q     <= l_valid_d;
      r_valid_q     <= r_valid_d;
      frame_valid_q <= frame_valid_d;
      short_frame_q <= short_frame_d;
      frame_ok_q    <= frame_ok_d;
    end
  end

  assign l_chan_o      = l_chan_q;
  assign r_chan_o      = r_chan_q;
  assign l_valid_o     = l_valid_q;
  assign r_valid_o     = r_valid_q;
  assign frame_valid_o = frame_valid_q;
  assign short_frame_o = short_frame_q;

endmodule

// File: doc/i2s_decoder.md
I2S_DECODER -- requirements
Module: i2s_decoder

Interface
REQ-001 Parameter: DATA_BITS, default 16, width of each channel word captured per LRCLK half-period.
REQ-002 Port: clk  input  1  system clock, 48 MHz; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: lrclk_i  input  1  external I2S word clock, asynchronous to clk; 0 = left, 1 = right.
REQ-005 Port: bclk_i  input  1  external I2S bit clock, asynchronous to clk; data sampled on its rising edge.
REQ-006 Port: dacdat_i  input  1  external I2S serial data, MSB-first.
REQ-007 Port: l_chan_o  output  DATA_BITS  last complete left word.
REQ-008 Port: r_chan_o  output  DATA_BITS  last complete right word.
REQ-009 Port: l_valid_o  output  1  one-clk pulse when l_chan_o updates.
REQ-010 Port: r_valid_o  output  1  one-clk pulse when r_chan_o updates.
REQ-011 Port: frame_valid_o  output  1  one-clk pulse when a right word completes and the preceding left word was also complete.
REQ-012 Port: short_frame_o  output  1  one-clk pulse when an LRCLK edge arrives before DATA_BITS bits were captured.

Function
REQ-013 Inputs SHALL pass a synchronizer (REQ-030/031), then one history register for edge detection; edges are detected in the clk domain only.
REQ-014 States SHALL be IDLE, SKIP, SHIFT, HOLD.
REQ-015 IDLE: ignore bclk; on any synchronized LRCLK edge -> SKIP, latch channel = new LRCLK level.
REQ-016 SKIP: first synchronized BCLK rising edge is the I2S one-bit delay slot, discarded -> SHIFT, bit counter = 0.
REQ-017 SHIFT: each BCLK rising edge shifts dacdat into LSB of a DATA_BITS shifter, counter +1; when counter reaches DATA_BITS -> HOLD.
REQ-018 HOLD entry: shifter copied to l_chan_o or r_chan_o per latched channel; matching valid pulse asserted the clk after the DATA_BITS-th edge is detected.
REQ-019 HOLD: further BCLK edges ignored (surplus bits, e.g. 30 BCLKs per half-period) until next LRCLK edge.
REQ-020 Any LRCLK edge in SKIP, SHIFT or HOLD -> SKIP with new channel; in SKIP/SHIFT also pulse short_frame_o, discard partial word, outputs unchanged.
REQ-021 LRCLK edge and BCLK rising edge detected in the same clk: LRCLK edge wins; that BCLK edge SHALL count as the delay slot (state -> SHIFT directly).
REQ-022 frame_valid_o pulses with r_valid_o only if the last left half-period completed without short_frame; a short frame clears this flag.
REQ-023 Bit counter SHALL be ceil(log2(DATA_BITS+1)) wide and never wrap; saturates in HOLD.
REQ-024 Pulse outputs never high two consecutive clks; l_chan_o/r_chan_o hold value between updates.

Reset
REQ-025 rst high at a clk edge: state = IDLE, counter = 0, shifter = 0.
REQ-026 Reset values: l_chan_o = 0, r_chan_o = 0, all pulse outputs = 0, frame flag cleared.
REQ-027 Reset mid-word SHALL discard the partial word without any pulse; synchronizer stages also cleared to 0.
REQ-028 After reset release, first word captured only after a fresh LRCLK edge (IDLE).
REQ-029 No output changes combinationally from rst.

Configuration
REQ-030 Macro I2S_DECODER_SYNC2_EN defined: two flip-flop synchronizer per input; input-to-detection latency 3 clks.
REQ-031 Macro undefined: single flip-flop input register; latency 2 clks; all other behaviour identical.

Verification
REQ-032 Codebase I2S encoder (LRCLK_DIV 982, BCLK_DIV 15) with l=16'h8001, r=16'h7FFE -> l_chan_o=8001, r_chan_o=7FFE, l/r/frame_valid one pulse each per 983 clks.
REQ-033 Encoder words 16'hFFFF/16'h0000 alternating every frame -> outputs track exactly, no short_frame_o.
REQ-034 LRCLK toggled after 9 BCLK edges -> short_frame_o pulse, outputs unchanged, next right word gives r_valid_o but no frame_valid_o.
REQ-035 rst pulsed after 8 bits of left word -> all outputs 0, no pulses until next full word after new LRCLK edge.
REQ-036 LRCLK edge and BCLK rise coincident in same clk -> following 16 BCLK rises captured; word correct.
REQ-037 Run REQ-032 with and without I2S_DECODER_SYNC2_EN -> identical words, valid pulses 1 clk later when defined.
